uart_bridge: RTL and testbench

Serial-port controller between the data-memory path (MemoryModule) and the board UART chip, which shares Ram1 data bits [7:0].
- Turns CPU data/status accesses into the chip's rdn/wrn/data_ready/tbre/tsre handshake.
- Buffers received bytes in a small RX FIFO, so reads of address 0xBF00 do not stall.
- Drives a stall request that feeds the pipeline's noStop/uartConflict path.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_bridge.sv | 153 +++++++++++++++
 tb/tb_uart_bridge.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART bridge: FSM state encoding, the two
// memory-mapped register addresses, and bit positions in the status word.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RX_STROBE = 3'd1,
        ST_TX_SETUP  = 3'd2,
        ST_TX_STROBE = 3'd3,
        ST_TX_WAIT   = 3'd4
    } uart_state_t;

    localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

    localparam int TX_READY_BIT = 0;
    localparam int RX_AVAIL_BIT = 1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: circular buffer of RX_DEPTH bytes (power of two).
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   push, din       write din at the tail
//   pop, dout       dout is the head byte; pop advances past it
//   empty, full     occupancy flags
//   count           number of stored bytes (0..RX_DEPTH)
// A simultaneous push and pop is accepted even when full, because the pop
// frees the slot the push fills.
module uart_rx_fifo #(
    parameter int RX_DEPTH = 4,
    parameter int DATA_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_W-1:0]           din,
    output logic [DATA_W-1:0]           dout,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(RX_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [RX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RX_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_bridge.sv
// Bridge between the CPU data-memory path and the board UART chip sharing
// Ram1 data [7:0].
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   req_read / req_status     CPU reads data (0xBF00) / status (0xBF01)
//   req_write, wdata          CPU write of a byte to transmit
//   rdata                     combinational read result
//   busy                      stall request while a write cannot be taken
//   data_ready, tbre, tsre    UART chip status inputs
//   rdn, wrn                  UART read/write strobes, active low
//   bus_in, bus_out, bus_oe   shared Ram1 byte lane and its drive enable
//
// state     | meaning
// IDLE      | waiting; pending TX wins over a waiting RX byte
// RX_STROBE | rdn low; byte on bus_in captured on the last cycle
// TX_SETUP  | bus driven with the tx byte, wrn still high
// TX_STROBE | wrn low with the bus still driven
// TX_WAIT   | wait for tbre and tsre both high
module uart_bridge
    import uart_pkg::*;
#(
    parameter int RX_DEPTH      = 4,
    parameter int STROBE_CYCLES = 2,
    parameter int DATA_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_status,
    input  logic              req_write,
    input  logic [DATA_W-1:0] wdata,
    output logic [15:0]       rdata,
    output logic              busy,
    input  logic              data_ready,
    input  logic              tbre,
    input  logic              tsre,
    output logic              rdn,
    output logic              wrn,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe
);

    localparam int              SC_W    = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_LOAD = SC_W'(STROBE_CYCLES - 1);
    localparam int              CNT_W   = $clog2(RX_DEPTH) + 1;

    uart_state_t       state;
    uart_state_t       state_nxt;
    logic [SC_W-1:0]   strobe_cnt;
    logic              strobe_done;
    logic              tx_pending;
    logic [DATA_W-1:0] tx_data;
    logic              in_tx;
    logic              tx_accept;
    logic              tx_done;
    logic              tx_ready;
    logic              rx_push;
    logic              rx_pop;
    logic              rx_empty;
    logic              rx_full;
    logic [DATA_W-1:0] rx_head;
    logic [CNT_W-1:0]  rx_count_unused;
    logic              rdn_nxt;
    logic              wrn_nxt;
    logic              oe_nxt;

    uart_rx_fifo #(
        .RX_DEPTH (RX_DEPTH),
        .DATA_W   (DATA_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (bus_in),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count_unused)
    );

    assign in_tx       = state inside {ST_TX_SETUP, ST_TX_STROBE, ST_TX_WAIT};
    assign strobe_done = (strobe_cnt == '0);
    assign busy        = req_write && (tx_pending || in_tx);
    assign tx_accept   = req_write && !tx_pending && !in_tx;
    assign tx_done     = (state == ST_TX_STROBE) && strobe_done;
    assign tx_ready    = !tx_pending && !in_tx && tbre && tsre;
    assign rx_push     = (state == ST_RX_STROBE) && strobe_done;
    assign rx_pop      = req_read && !rx_empty;
    assign bus_out     = tx_data;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (tx_pending)                   state_nxt = ST_TX_SETUP;
                else if (data_ready && !rx_full)  state_nxt = ST_RX_STROBE;
            end
            ST_RX_STROBE: if (strobe_done)        state_nxt = ST_IDLE;
            ST_TX_SETUP:                          state_nxt = ST_TX_STROBE;
            ST_TX_STROBE: if (strobe_done)        state_nxt = ST_TX_WAIT;
            ST_TX_WAIT:   if (tbre && tsre)       state_nxt = ST_IDLE;
            default:                              state_nxt = ST_IDLE;
        endcase

        // Strobes and the bus enable are registered from the next state so
        // the chip sees glitch-free edges.
        rdn_nxt = (state_nxt != ST_RX_STROBE);
        wrn_nxt = (state_nxt != ST_TX_STROBE);
        oe_nxt  = (state_nxt == ST_TX_SETUP) || (state_nxt == ST_TX_STROBE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            strobe_cnt <= SC_LOAD;
            rdn        <= 1'b1;
            wrn        <= 1'b1;
            bus_oe     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)  strobe_cnt <= SC_LOAD;
            else if (!strobe_done)   strobe_cnt <= strobe_cnt - 1'b1;
            rdn    <= rdn_nxt;
            wrn    <= wrn_nxt;
            bus_oe <= oe_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_pending <= 1'b0;
            tx_data    <= '0;
        end else if (tx_accept) begin
            tx_pending <= 1'b1;
            tx_data    <= wdata;
        end else if (tx_done) begin
            tx_pending <= 1'b0;
        end
    end

    always_comb begin
        rdata = 16'h0000;
        if (req_read) begin
            if (!rx_empty) rdata[DATA_W-1:0] = rx_head;
        end else if (req_status) begin
            rdata[RX_AVAIL_BIT] = !rx_empty;
            rdata[TX_READY_BIT] = tx_ready;
        end
    end

endmodule

// File: tb/tb_uart_bridge.sv
module tb_uart_bridge;

    localparam int RX_DEPTH      = 4;
    localparam int STROBE_CYCLES = 2;
    localparam int DATA_W        = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read, req_status, req_write;
    logic [7:0]  wdata;
    logic [15:0] rdata;
    logic        busy;
    logic        data_ready, tbre, tsre;
    logic        rdn, wrn;
    logic [7:0]  bus_in, bus_out;
    logic        bus_oe;

    logic        f_push, f_pop;
    logic [7:0]  f_din, f_dout;
    logic        f_empty, f_full;
    logic [2:0]  f_count;

    always #5 clk = ~clk;

    uart_bridge #(
        .RX_DEPTH      (RX_DEPTH),
        .STROBE_CYCLES (STROBE_CYCLES),
        .DATA_W        (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_read   (req_read),
        .req_status (req_status),
        .req_write  (req_write),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre),
        .rdn        (rdn),
        .wrn        (wrn),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe)
    );

    uart_rx_fifo #(
        .RX_DEPTH (RX_DEPTH),
        .DATA_W   (DATA_W)
    ) fifo_u (
        .clk   (clk),
        .rst   (rst),
        .push  (f_push),
        .pop   (f_pop),
        .din   (f_din),
        .dout  (f_dout),
        .empty (f_empty),
        .full  (f_full),
        .count (f_count)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] chip_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] fexp_q[$];

    int   rd_low = 0, wr_low = 0;
    int   rd_strobes = 0, wr_strobes = 0;
    int   rd_last_w = 0, wr_last_w = 0;
    logic rdn_prev = 1'b1, wrn_prev = 1'b1;

    // One clock step, plus a model of the UART chip: a byte leaves the chip
    // when the read strobe it was read with is released.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rdn && !rdn_prev) begin
            rd_strobes++;
            rd_last_w = rd_low;
            rd_low = 0;
            if (chip_q.size() > 0) void'(chip_q.pop_front());
        end else if (!rdn) begin
            rd_low++;
        end
        if (wrn && !wrn_prev) begin
            wr_strobes++;
            wr_last_w = wr_low;
            wr_low = 0;
        end else if (!wrn) begin
            wr_low++;
        end
        rdn_prev = rdn;
        wrn_prev = wrn;
        data_ready = (chip_q.size() > 0);
        bus_in = (chip_q.size() > 0) ? chip_q[0] : 8'h00;
    endtask

    task automatic chip_load(input logic [7:0] b);
        chip_q.push_back(b);
        exp_q.push_back(b);
        data_ready = 1'b1;
        bus_in = chip_q[0];
    endtask

    task automatic do_read(output logic [15:0] d);
        req_read = 1'b1;
        #1;
        d = rdata;
        tick();
        req_read = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        int snap;
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        tbre = 1'b1; tsre = 1'b1;
        req_write = 1'b1; wdata = 8'hA5;
        tick();
        req_write = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (!wrn) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL reset_reach_tx_strobe: wrn never went low"); end
        rst = 1'b0; tbre = 1'b0; tsre = 1'b0;
        tick();
        checks++;
        if (wrn !== 1'b1) begin errors++; $display("FAIL reset_wrn_next_cycle: got %b want 1", wrn); end
        repeat (2) tick();
        checks++;
        if (rdn !== 1'b1) begin errors++; $display("FAIL reset_rdn: got %b want 1", rdn); end
        checks++;
        if (bus_oe !== 1'b0) begin errors++; $display("FAIL reset_bus_oe: got %b want 0", bus_oe); end
        checks++;
        if (bus_out !== 8'h00) begin errors++; $display("FAIL reset_bus_out: got %h want 00", bus_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        req_status = 1'b1;
        #1;
        checks++;
        if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_status: got %h want 0000", rdata); end
        req_status = 1'b0;
        rst = 1'b1;
        tbre = 1'b1; tsre = 1'b1;
        tick();
        snap = wr_strobes;
        req_status = 1'b1;
        #1;
        checks++;
        if (rdata !== 16'h0001) begin errors++; $display("FAIL reset_tx_dropped_status: got %h want 0001", rdata); end
        req_status = 1'b0;
        repeat (6) tick();
        checks++;
        if (wr_strobes !== snap || wr_low !== 0) begin
            errors++; $display("FAIL reset_no_tx_resume: strobes %0d low %0d want %0d 0", wr_strobes, wr_low, snap);
        end
    endtask

    task automatic test_rx_single();
        int s;
        bit seen;
        logic [15:0] d;
        logic [7:0]  e;
        tbre = 1'b0; tsre = 1'b0;
        s = rd_strobes;
        chip_load(8'h5A);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (rd_strobes != s) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rx_single_strobe: no rdn strobe seen"); end
        checks++;
        if (rd_last_w !== STROBE_CYCLES) begin errors++; $display("FAIL rx_single_width: got %0d want %0d", rd_last_w, STROBE_CYCLES); end
        req_status = 1'b1;
        #1;
        checks++;
        if (rdata !== 16'h0002) begin errors++; $display("FAIL rx_single_status: got %h want 0002", rdata); end
        req_status = 1'b0;
        do_read(d);
        e = exp_q.pop_front();
        checks++;
        if (d !== {8'h00, e}) begin errors++; $display("FAIL rx_single_read: got %h want %h", d, {8'h00, e}); end
        req_status = 1'b1;
        #1;
        checks++;
        if (rdata[1] !== 1'b0) begin errors++; $display("FAIL rx_single_avail_clear: got %b want 0", rdata[1]); end
        req_status = 1'b0;
    endtask

    task automatic test_rx_overflow();
        int s;
        logic [15:0] d;
        logic [7:0]  e;
        s = rd_strobes;
        for (int k = 1; k <= 6; k++) chip_load(8'(k));
        repeat (30) tick();
        checks++;
        if (rd_strobes - s !== 4) begin errors++; $display("FAIL rx_overflow_strobes: got %0d want 4", rd_strobes - s); end
        checks++;
        if (!data_ready || chip_q.size() != 2) begin
            errors++; $display("FAIL rx_overflow_left_in_chip: got %0d want 2", chip_q.size());
        end
        do_read(d);
        e = exp_q.pop_front();
        checks++;
        if (d !== {8'h00, e}) begin errors++; $display("FAIL rx_overflow_read_first: got %h want %h", d, {8'h00, e}); end
        repeat (10) tick();
        checks++;
        if (rd_strobes - s !== 5) begin errors++; $display("FAIL rx_overflow_fifth: got %0d want 5", rd_strobes - s); end
        for (int k = 0; k < 6 && exp_q.size() > 0; k++) begin
            do_read(d);
            e = exp_q.pop_front();
            checks++;
            if (d !== {8'h00, e}) begin errors++; $display("FAIL rx_overflow_order: got %h want %h", d, {8'h00, e}); end
            repeat (6) tick();
        end
        req_status = 1'b1;
        #1;
        checks++;
        if (rdata[1] !== 1'b0) begin errors++; $display("FAIL rx_overflow_drained: avail %b want 0", rdata[1]); end
        req_status = 1'b0;
    endtask

    task automatic test_tx();
        int s, setup, oe_bad, busy_hi;
        s = wr_strobes;
        setup = 0; oe_bad = 0; busy_hi = 0;
        tbre = 1'b1; tsre = 1'b1;
        req_write = 1'b1; wdata = 8'hC3;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL tx_accept_busy: got %b want 0", busy); end
        tick();
        req_write = 1'b0;
        tbre = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_oe && wrn) begin
                setup++;
                checks++;
                if (bus_out !== 8'hC3) begin errors++; $display("FAIL tx_setup_bus_out: got %h want c3", bus_out); end
            end
            if (!wrn && !bus_oe) oe_bad++;
        end
        checks++;
        if (setup !== 1) begin errors++; $display("FAIL tx_setup_cycles: got %0d want 1", setup); end
        checks++;
        if (wr_strobes - s !== 1 || wr_last_w !== STROBE_CYCLES) begin
            errors++; $display("FAIL tx_strobe: count %0d width %0d want 1 %0d", wr_strobes - s, wr_last_w, STROBE_CYCLES);
        end
        checks++;
        if (oe_bad !== 0 || bus_oe !== 1'b0) begin errors++; $display("FAIL tx_bus_oe: bad %0d oe %b want 0 0", oe_bad, bus_oe); end
        req_write = 1'b1; wdata = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (busy) busy_hi++;
            tick();
        end
        checks++;
        if (busy_hi !== 10) begin errors++; $display("FAIL tx_wait_busy: got %0d want 10", busy_hi); end
        tbre = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL tx_busy_release: got %b want 0", busy); end
        tick();
        req_write = 1'b0;
        repeat (12) tick();
        checks++;
        if (wr_strobes - s !== 2) begin errors++; $display("FAIL tx_second_byte: got %0d want 2", wr_strobes - s); end
    endtask

    task automatic test_priority();
        int t_wr, t_rd;
        bit seen, rd_hi;
        logic [15:0] d;
        logic [7:0]  e;
        tbre = 1'b1; tsre = 1'b1;
        chip_load(8'hA1);
        chip_load(8'hA2);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (!rdn) seen = 1;
        end
        req_write = 1'b1; wdata = 8'h5E;
        #1;
        checks++;
        if (!seen || busy !== 1'b0) begin errors++; $display("FAIL prio_write_during_rx: seen %b busy %b want 1 0", seen, busy); end
        tick();
        req_write = 1'b0;
        t_wr = -1; t_rd = -1; rd_hi = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!wrn && t_wr < 0) t_wr = i;
            if (rdn) rd_hi = 1;
            else if (rd_hi && t_rd < 0) t_rd = i;
        end
        checks++;
        if (t_wr < 0 || t_rd <= t_wr) begin errors++; $display("FAIL prio_tx_first: wr at %0d rd at %0d want wr first", t_wr, t_rd); end
        for (int k = 0; k < 2; k++) begin
            do_read(d);
            e = exp_q.pop_front();
            checks++;
            if (d !== {8'h00, e}) begin errors++; $display("FAIL prio_read: got %h want %h", d, {8'h00, e}); end
        end
    endtask

    task automatic test_fifo_full_pushpop();
        logic [7:0] e;
        f_push = 1'b1;
        for (int k = 0; k < 4; k++) begin
            f_din = 8'(8'h10 + k);
            fexp_q.push_back(f_din);
            tick();
        end
        f_push = 1'b0;
        #1;
        checks++;
        if (f_count !== 3'd4 || f_full !== 1'b1) begin errors++; $display("FAIL fifo_fill: count %0d full %b want 4 1", f_count, f_full); end
        f_push = 1'b1; f_pop = 1'b1; f_din = 8'h14;
        fexp_q.push_back(f_din);
        e = fexp_q.pop_front();
        #1;
        checks++;
        if (f_dout !== e) begin errors++; $display("FAIL fifo_pushpop_head: got %h want %h", f_dout, e); end
        tick();
        f_push = 1'b0;
        #1;
        checks++;
        if (f_count !== 3'd4) begin errors++; $display("FAIL fifo_pushpop_count: got %0d want 4", f_count); end
        for (int k = 0; k < 4; k++) begin
            e = fexp_q.pop_front();
            checks++;
            if (f_dout !== e) begin errors++; $display("FAIL fifo_pushpop_order: got %h want %h", f_dout, e); end
            tick();
        end
        f_pop = 1'b0;
        #1;
        checks++;
        if (f_empty !== 1'b1) begin errors++; $display("FAIL fifo_drain_empty: got %b want 1", f_empty); end
    endtask

    task automatic test_empty_read();
        int s;
        bit seen;
        logic [7:0] e;
        tbre = 1'b1; tsre = 1'b1;
        req_read = 1'b1; req_status = 1'b1;
        #1;
        checks++;
        if (rdata !== 16'h0000) begin errors++; $display("FAIL empty_read_wins: got %h want 0000", rdata); end
        req_status = 1'b0;
        #1;
        checks++;
        if (rdata !== 16'h0000) begin errors++; $display("FAIL empty_read: got %h want 0000", rdata); end
        tick();
        req_read = 1'b0;
        s = rd_strobes;
        chip_load(8'h9C);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (rd_strobes != s) seen = 1;
        end
        req_read = 1'b1; req_status = 1'b1;
        e = exp_q.pop_front();
        #1;
        checks++;
        if (!seen || rdata !== {8'h00, e}) begin errors++; $display("FAIL empty_read_ptrs: got %h want %h", rdata, {8'h00, e}); end
        tick();
        req_read = 1'b0;
        #1;
        checks++;
        if (rdata !== 16'h0001) begin errors++; $display("FAIL empty_read_status_after: got %h want 0001", rdata); end
        req_status = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        req_read = 1'b0; req_status = 1'b0; req_write = 1'b0;
        wdata = 8'h00;
        data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0;
        bus_in = 8'h00;
        f_push = 1'b0; f_pop = 1'b0; f_din = 8'h00;

        test_reset();
        test_rx_single();
        test_rx_overflow();
        test_tx();
        test_priority();
        test_fifo_full_pushpop();
        test_empty_read();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
